// File: rtl/data_mem_ctrl_if.sv
// Memory-stage to data-memory request/response bundle.
// Latency: none, wires only.
// Backpressure: none; the requester holds request until it sees valid.
// Ports: master = memory stage (drives request/we_re/mask/address/store_data),
//        slave  = data memory (drives load_data/valid/busy/err).
interface data_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32
);
    logic                  request;
    logic                  we_re;
    logic [3:0]            mask;
    logic [ADDRESS-1:0]    address;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  valid;
    logic                  busy;
    logic                  err;

    modport master (
        output request, we_re, mask, address, store_data,
        input  load_data, valid, busy, err
    );

    modport slave (
        input  request, we_re, mask, address, store_data,
        output load_data, valid, busy, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory slave: byte-masked stores and full-word loads on a word-addressed SRAM.
// Latency: valid pulses WAIT_CYCLES+1 cycles after the cycle request is sampled in IDLE.
// Backpressure: requests arriving while busy are dropped; the requester holds request until valid.
// Ports: clk, rst (sync, active-high), bus (slave side of data_mem_ctrl_if):
//        request/we_re/mask/address/store_data in, load_data/valid/busy/err out.
module data_mem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDRESS     = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LANES = DATA_WIDTH / 8;

    // The access itself commits on the edge that leaves the last wait cycle
    // (or the accept edge when WAIT_CYCLES=0), so the FSM is already back in
    // IDLE during the valid cycle and can accept the next request there.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt;

    logic                  cap_we;
    logic [3:0]            cap_mask;
    logic [ADDRESS-1:0]    cap_addr;
    logic [DATA_WIDTH-1:0] cap_data;

    logic                  accept;
    logic                  do_access;
    logic                  op_we;
    logic [3:0]            op_mask;
    logic [ADDRESS-1:0]    op_addr;
    logic [DATA_WIDTH-1:0] op_data;
    logic [IDX_W-1:0]      op_idx;
    logic                  op_oor;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    assign accept = (state == S_IDLE) && bus.request;

    // In IDLE only a zero-wait access can commit, and it must use the live
    // inputs because nothing has been captured yet.
    always_comb begin
        op_we   = cap_we;
        op_mask = cap_mask;
        op_addr = cap_addr;
        op_data = cap_data;
        if (state == S_IDLE) begin
            op_we   = bus.we_re;
            op_mask = bus.mask;
            op_addr = bus.address;
            op_data = bus.store_data;
        end
    end

    assign op_idx = op_addr[IDX_W+1:2];
    assign op_oor = (op_addr >> (IDX_W + 2)) != '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        do_access = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.request) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    do_access = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy = (state == S_WAIT);
    end

    // Operand capture; later input changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we   <= bus.we_re;
            cap_mask <= bus.mask;
            cap_addr <= bus.address;
            cap_data <= bus.store_data;
        end
    end

    // Completion registers. load_data only moves on a completed load.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid     <= 1'b0;
            bus.err       <= 1'b0;
            bus.load_data <= '0;
        end else begin
            bus.valid <= do_access;
            bus.err   <= do_access && op_oor;
            if (do_access && !op_we) begin
                bus.load_data <= op_oor ? '0 : mem[op_idx];
            end
        end
    end

    // Array has no reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && do_access && op_we && !op_oor) begin
            for (int i = 0; i < LANES; i++) begin
                if (op_mask[i]) begin
                    mem[op_idx][8*i +: 8] <= op_data[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance with two wait states, one with none.
// Directed table, multi-cycle corner sequences, then random traffic against a word-array model.
module tb_data_mem_ctrl;
    localparam int W     = 2;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.DATA_WIDTH(32), .ADDRESS(32)) bi2 ();
    data_mem_ctrl_if #(.DATA_WIDTH(32), .ADDRESS(32)) bi0 ();

    data_mem_ctrl #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_w2 (
        .clk (clk),
        .rst (rst),
        .bus (bi2)
    );

    data_mem_ctrl #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk (clk),
        .rst (rst),
        .bus (bi0)
    );

    int errors = 0;
    int checks = 0;

    // Reference: a plain word array per instance plus the last-loaded word.
    logic [31:0] mdl    [2][DEPTH];
    logic [31:0] mdl_ld [2];
    bit          me;
    logic [31:0] mld;

    typedef struct {
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_ld;
    } vec_t;
    vec_t tbl [20];

    function automatic void model_access(input int s, input bit we, input logic [3:0] m,
                                         input logic [31:0] a, input logic [31:0] d,
                                         output bit e, output logic [31:0] ld);
        int unsigned w;
        e = (a >= 32'(DEPTH * 4));
        w = a / 4;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (m[i]) mdl[s][w][8*i +: 8] = d[8*i +: 8];
            end else begin
                mdl_ld[s] = mdl[s][w];
            end
        end else if (!we) begin
            mdl_ld[s] = 32'h0;
        end
        ld = mdl_ld[s];
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return $urandom | (32'h1 << $urandom_range(12, 31));
        return {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One complete access on the two-wait instance, with timing checked each cycle.
    task automatic run_txn(input bit we, input logic [3:0] m, input logic [31:0] a,
                           input logic [31:0] d, input bit exp_err, input logic [31:0] exp_ld,
                           input bit scramble, input string tag);
        bi2.request    = 1'b1;
        bi2.we_re      = we;
        bi2.mask       = m;
        bi2.address    = a;
        bi2.store_data = d;
        step();
        for (int k = 1; k <= W; k++) begin
            chkb($sformatf("%s busy c%0d", tag, k), bi2.busy, 1'b1);
            chkb($sformatf("%s early valid c%0d", tag, k), bi2.valid, 1'b0);
            if (scramble) begin
                bi2.request    = 1'($urandom);
                bi2.we_re      = 1'($urandom);
                bi2.mask       = 4'($urandom);
                bi2.address    = $urandom;
                bi2.store_data = $urandom;
            end
            step();
        end
        chkb({tag, " valid"}, bi2.valid, 1'b1);
        chkb({tag, " busy at done"}, bi2.busy, 1'b0);
        chkb({tag, " err"}, bi2.err, exp_err);
        chk({tag, " load_data"}, bi2.load_data, exp_ld);
        bi2.request = 1'b0;
        step();
        chkb({tag, " valid width"}, bi2.valid, 1'b0);
        chkb({tag, " err idle"}, bi2.err, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit          rq, rw;
        logic [3:0]  rm;
        logic [31:0] ra, rd;

        tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h11223344, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 4'h4, 32'h0000_0020, 32'h00AB0000, 1'b0, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,        1'b0, 32'h11AB3344};
        tbl[5]  = '{1'b1, 4'h1, 32'h0000_0020, 32'h000000CD, 1'b0, 32'h11AB3344};
        tbl[6]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,        1'b0, 32'h11AB33CD};
        tbl[7]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hCAFEF00D, 1'b0, 32'h11AB33CD};
        tbl[8]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h01234567, 1'b0, 32'h11AB33CD};
        tbl[9]  = '{1'b1, 4'hF, 32'h0000_0030, 32'h55AA55AA, 1'b0, 32'h11AB33CD};
        tbl[10] = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFFFFFF, 1'b1, 32'h11AB33CD};
        tbl[11] = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,        1'b1, 32'h0000_0000};
        tbl[12] = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,        1'b0, 32'hCAFEF00D};
        tbl[13] = '{1'b1, 4'h0, 32'h0000_0004, 32'hFFFFFFFF, 1'b0, 32'hCAFEF00D};
        tbl[14] = '{1'b0, 4'h0, 32'h0000_0004, 32'h0,        1'b0, 32'h01234567};
        tbl[15] = '{1'b0, 4'h0, 32'h0000_0013, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[16] = '{1'b1, 4'hF, 32'h8000_0010, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[17] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[18] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h0BADC0DE, 1'b0, 32'hDEADBEEF};
        tbl[19] = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0,        1'b0, 32'h0BADC0DE};

        mdl_ld[0] = 32'h0;
        mdl_ld[1] = 32'h0;
        bi2.request = 1'b0; bi2.we_re = 1'b0; bi2.mask = 4'h0; bi2.address = 32'h0; bi2.store_data = 32'h0;
        bi0.request = 1'b0; bi0.we_re = 1'b0; bi0.mask = 4'h0; bi0.address = 32'h0; bi0.store_data = 32'h0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chkb("rst w2 valid", bi2.valid, 1'b0);
        chkb("rst w2 busy", bi2.busy, 1'b0);
        chkb("rst w2 err", bi2.err, 1'b0);
        chk("rst w2 load_data", bi2.load_data, 32'h0);
        chkb("rst w0 valid", bi0.valid, 1'b0);
        chk("rst w0 load_data", bi0.load_data, 32'h0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 20; i++) begin
            model_access(0, tbl[i].we, tbl[i].mask, tbl[i].addr, tbl[i].data, me, mld);
            run_txn(tbl[i].we, tbl[i].mask, tbl[i].addr, tbl[i].data,
                    tbl[i].exp_err, tbl[i].exp_ld, 1'b0, $sformatf("vec%0d", i));
        end

        // Request held high across two loads: valid in cycles 3 and 6 only.
        bi2.request = 1'b1; bi2.we_re = 1'b0; bi2.mask = 4'hF; bi2.address = 32'h0;
        for (int c = 1; c <= 7; c++) begin
            step();
            chkb($sformatf("b2b valid c%0d", c), bi2.valid, (c == 3 || c == 6));
            if (c == 3) begin
                chk("b2b first load", bi2.load_data, 32'hCAFEF00D);
                bi2.address = 32'h4;
            end
            if (c == 6) begin
                chk("b2b second load", bi2.load_data, 32'h01234567);
                bi2.request = 1'b0;
            end
        end
        model_access(0, 1'b0, 4'hF, 32'h0, 32'h0, me, mld);
        model_access(0, 1'b0, 4'hF, 32'h4, 32'h0, me, mld);

        // A store request raised while busy is ignored.
        bi2.request = 1'b1; bi2.we_re = 1'b0; bi2.address = 32'h10;
        step();
        chkb("ign busy c1", bi2.busy, 1'b1);
        bi2.we_re = 1'b1; bi2.address = 32'h30; bi2.store_data = 32'h0; bi2.mask = 4'hF;
        step();
        bi2.request = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            chkb($sformatf("ign valid c%0d", c), bi2.valid, (c == 3));
            if (c == 3) chk("ign load", bi2.load_data, 32'hDEADBEEF);
            step();
        end
        model_access(0, 1'b0, 4'hF, 32'h10, 32'h0, me, mld);
        model_access(0, 1'b0, 4'hF, 32'h30, 32'h0, me, mld);
        run_txn(1'b0, 4'hF, 32'h30, 32'h0, me, mld, 1'b0, "ign check");

        // Reset in the middle of a store aborts it.
        bi2.request = 1'b1; bi2.we_re = 1'b1; bi2.mask = 4'hF;
        bi2.address = 32'h30; bi2.store_data = 32'h12345678;
        step();
        chkb("rstmid busy c1", bi2.busy, 1'b1);
        rst = 1'b1;
        bi2.request = 1'b0;
        step();
        rst = 1'b0;
        mdl_ld[0] = 32'h0;
        mdl_ld[1] = 32'h0;
        chkb("rstmid busy", bi2.busy, 1'b0);
        chkb("rstmid valid", bi2.valid, 1'b0);
        chk("rstmid load_data", bi2.load_data, 32'h0);
        for (int c = 3; c <= 6; c++) begin
            step();
            chkb($sformatf("rstmid no valid c%0d", c), bi2.valid, 1'b0);
        end
        model_access(0, 1'b0, 4'hF, 32'h30, 32'h0, me, mld);
        run_txn(1'b0, 4'hF, 32'h30, 32'h0, me, mld, 1'b0, "rstmid reload");

        // Random traffic with operands scrambled while busy.
        for (int w = 0; w < 64; w++) begin
            rd = $urandom;
            model_access(0, 1'b1, 4'hF, 32'(w * 4), rd, me, mld);
            run_txn(1'b1, 4'hF, 32'(w * 4), rd, me, mld, 1'b0, "init2");
        end
        for (int n = 0; n < 120; n++) begin
            rw = 1'($urandom);
            rm = 4'($urandom);
            ra = rand_addr();
            rd = $urandom;
            model_access(0, rw, rm, ra, rd, me, mld);
            run_txn(rw, rm, ra, rd, me, mld, 1'b1, $sformatf("rnd2_%0d", n));
        end

        // Zero-wait instance: store, then a load in cycle 0 completes in cycle 1.
        bi0.request = 1'b1; bi0.we_re = 1'b1; bi0.mask = 4'hF;
        bi0.address = 32'h40; bi0.store_data = 32'hA5A5A5A5;
        step();
        chkb("w0 store valid", bi0.valid, 1'b1);
        chkb("w0 busy", bi0.busy, 1'b0);
        chkb("w0 store err", bi0.err, 1'b0);
        bi0.we_re = 1'b0;
        step();
        chkb("w0 load valid", bi0.valid, 1'b1);
        chk("w0 load data", bi0.load_data, 32'hA5A5A5A5);
        bi0.request = 1'b0;
        step();
        chkb("w0 valid drops", bi0.valid, 1'b0);
        chk("w0 load holds", bi0.load_data, 32'hA5A5A5A5);
        model_access(1, 1'b1, 4'hF, 32'h40, 32'hA5A5A5A5, me, mld);
        model_access(1, 1'b0, 4'hF, 32'h40, 32'h0, me, mld);

        // Continuous zero-wait stream: one completion per cycle.
        for (int w = 0; w < 64; w++) begin
            rd = $urandom;
            bi0.request = 1'b1; bi0.we_re = 1'b1; bi0.mask = 4'hF;
            bi0.address = 32'(w * 4); bi0.store_data = rd;
            model_access(1, 1'b1, 4'hF, 32'(w * 4), rd, me, mld);
            step();
            chkb($sformatf("w0 init valid %0d", w), bi0.valid, 1'b1);
        end
        for (int n = 0; n < 200; n++) begin
            rq = ($urandom_range(0, 3) != 0);
            rw = 1'($urandom);
            rm = 4'($urandom);
            ra = rand_addr();
            rd = $urandom;
            bi0.request = rq; bi0.we_re = rw; bi0.mask = rm; bi0.address = ra; bi0.store_data = rd;
            if (rq) model_access(1, rw, rm, ra, rd, me, mld);
            else begin
                me  = 1'b0;
                mld = mdl_ld[1];
            end
            step();
            chkb($sformatf("rnd0_%0d valid", n), bi0.valid, rq);
            chkb($sformatf("rnd0_%0d busy", n), bi0.busy, 1'b0);
            chkb($sformatf("rnd0_%0d err", n), bi0.err, me);
            chk($sformatf("rnd0_%0d load_data", n), bi0.load_data, mld);
        end
        bi0.request = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory slave placed directly downstream of the core's memory stage.
- Accepts the memory stage's request/we_re/mask/address/store-data handshake and performs byte-masked stores or full-word loads on an internal word-addressed SRAM array.
- Each access takes a programmable number of wait states; completion is signalled with a one-cycle valid pulse. Load data is returned to the core's load-wrapping logic.

Parameters:
- DATA_WIDTH, 32, data word width in bits (fixed 32; mask is 4 bits).
- ADDRESS, 32, byte address width.
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, at least 4).
- WAIT_CYCLES, 2, wait states inserted between accept and completion (0 to 15).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous active-high reset.
- request  input  1  access request from the memory stage.
- we_re  input  1  1 = store, 0 = load.
- mask  input  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
- address  input  ADDRESS  byte address; bits 1:0 are ignored.
- store_data  input  DATA_WIDTH  lane-aligned store data.
- load_data  output  DATA_WIDTH  registered full-word read data.
- valid  output  1  one-cycle completion pulse; this is the core's DM_valid.
- busy  output  1  high while an access is in flight.
- err  output  1  out-of-range flag, qualified by valid.

Behaviour:
- Reset values: valid=0, busy=0, err=0, load_data=0, state=IDLE, wait counter=0. Array contents are not reset.
- Reset asserted mid-access: the access is aborted, no write occurs, and no valid is produced.
- States:
  - IDLE: if request=1, capture we_re, mask, address and store_data. Set busy=1 and load counter=WAIT_CYCLES. Go to WAIT, or to ACCESS if WAIT_CYCLES=0.
  - WAIT: decrement the counter each cycle. When counter=1 (decrementing to 0), go to ACCESS.
  - ACCESS: perform the access on this edge, register valid=1 and busy=0, and return to IDLE.
- Latency: with request sampled high in IDLE during cycle T, valid is high during cycle T+1+WAIT_CYCLES. With WAIT_CYCLES=0, valid is high in T+1.
- valid is high for exactly one cycle per accepted request.
- Throughput: a request present while valid is high is accepted (state is already IDLE). Maximum rate is one access per WAIT_CYCLES+1 cycles.
- request while busy=1 is ignored and not queued. The memory stage must hold request until it sees valid.
- Captured operands are used. Input changes after accept have no effect.
- Word index = address[log2(DEPTH_WORDS)+1 : 2].
- Out of range: address bits ADDRESS-1 down to log2(DEPTH_WORDS)+2 are nonzero. Then:
  - A store writes nothing.
  - A load sets load_data=0.
  - err=1 alongside valid.
  - Otherwise err=0 with valid.
- Store: for each i with mask[i]=1, write byte lane i of the word; other lanes are unchanged. mask=0000 completes with valid but modifies nothing. load_data holds its previous value.
- Load: load_data = full word at the index, reflecting every store committed on earlier edges. mask is ignored; lane extraction and sign extension stay in the memory stage.
- load_data holds its value until the next load completes.
- err is deasserted whenever valid=0.

Test Plan:
- WAIT_CYCLES=2, store addr 0x10, data 0xDEADBEEF, mask 1111, request in cycle 0:
  - busy=1 in cycles 1-2.
  - valid=1 only in cycle 3, err=0.
  - A following load of 0x10 returns load_data=0xDEADBEEF with valid 3 cycles after its accept.
- Byte merge:
  - Preload 0x20=0x11223344.
  - Store mask 0100, data 0x00AB0000, then load 0x20: load_data=0x11AB3344.
  - A second store with mask 0001, data 0x000000CD gives 0x11AB33CD.
- Back-to-back and ignore:
  - Request held high continuously (loads from 0x0, 0x4): valid pulses in cycles 3 and 6.
  - A request toggled high in cycle 1 only, while busy, produces no valid.
- Out of range, DEPTH_WORDS=1024: store to 0x00001000 then load 0x00001000:
  - Both complete with valid=1 and err=1.
  - load_data=0.
  - Word 0 is unchanged.
- Reset mid-op: store to 0x30 accepted in cycle 0, rst=1 in cycle 1:
  - valid never asserts and busy=0 after the reset edge.
  - A subsequent load of 0x30 returns the pre-store value.
- WAIT_CYCLES=0: load request in cycle 0 gives valid in cycle 1. Continuous requests give valid every cycle.
